// File: rtl/scl_gen.sv
// SCL clock generator for the APB I2C master: drives the open-drain SCL pad,
// honours slave clock stretching and emits bit-timing strobes for the controller.
module scl_gen #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      scl_gen_en,
  input  logic                      scl_run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] stretch_limit,
  input  logic                      scl_in,
  output logic                      scl_oe,
  output logic                      scl_fall_strb,
  output logic                      scl_rise_strb,
  output logic                      mid_low_strb,
  output logic                      mid_high_strb,
  output logic                      stretching,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [PRESCALE_WIDTH-1:0] One = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] Two = PRESCALE_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, LOW, WAIT_HIGH, HIGH} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] stretch_cnt_q, stretch_cnt_d;
  logic [PRESCALE_WIDTH-1:0] pl_q, pl_d;
  logic [SyncN-1:0]          sync_q;
  logic                      scl_sync;
  logic [PRESCALE_WIDTH-1:0] pl_new;
  logic [PRESCALE_WIDTH-1:0] half;

  logic scl_oe_q, fall_q, rise_q, mid_low_q, mid_high_q, stretching_q, timeout_q, busy_q;
  logic fall_d, rise_d, mid_low_d, mid_high_d, timeout_d;

  // Synchronizer idles high so a released bus is not mistaken for a stretch.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) sync_q <= '1;
    else        sync_q <= {sync_q[SyncN-2:0], scl_in};
  end

  assign scl_sync = sync_q[SyncN-1];
  assign pl_new   = (prescale < Two) ? Two : prescale;
  assign half     = pl_q >> 1;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stretch_cnt_q <= '0;
      pl_q          <= '0;
      scl_oe_q      <= 1'b0;
      fall_q        <= 1'b0;
      rise_q        <= 1'b0;
      mid_low_q     <= 1'b0;
      mid_high_q    <= 1'b0;
      stretching_q  <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      pl_q          <= pl_d;
      scl_oe_q      <= (state_d == LOW);
      fall_q        <= fall_d;
      rise_q        <= rise_d;
      mid_low_q     <= mid_low_d;
      mid_high_q    <= mid_high_d;
      stretching_q  <= (state_d == WAIT_HIGH);
      timeout_q     <= timeout_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  // Strobes are decided one cycle early so they appear registered with the state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stretch_cnt_d = stretch_cnt_q;
    pl_d          = pl_q;
    fall_d        = 1'b0;
    rise_d        = 1'b0;
    mid_low_d     = 1'b0;
    mid_high_d    = 1'b0;
    timeout_d     = 1'b0;

    if (!scl_gen_en) begin
      state_d       = IDLE;
      cnt_d         = '0;
      stretch_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scl_run) begin
            state_d = LOW;
            pl_d    = pl_new;
            cnt_d   = pl_new - One;
            fall_d  = 1'b1;
          end
        end
        LOW: begin
          cnt_d = cnt_q - One;
          if (cnt_q == half) mid_low_d = 1'b1;
          if (cnt_q == '0) begin
            state_d       = WAIT_HIGH;
            cnt_d         = '0;
            stretch_cnt_d = '0;
          end
        end
        WAIT_HIGH: begin
          stretch_cnt_d = stretch_cnt_q + One;
          if (scl_sync) begin
            state_d       = HIGH;
            cnt_d         = pl_q - One;
            stretch_cnt_d = '0;
            rise_d        = 1'b1;
          end else if ((stretch_limit != '0) && (stretch_cnt_q == stretch_limit)) begin
            state_d       = IDLE;
            stretch_cnt_d = '0;
            timeout_d     = 1'b1;
          end
        end
        HIGH: begin
          cnt_d = cnt_q - One;
          if (cnt_q == half) mid_high_d = 1'b1;
          if (cnt_q == '0) begin
            if (scl_run) begin
              state_d = LOW;
              pl_d    = pl_new;
              cnt_d   = pl_new - One;
              fall_d  = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign scl_oe        = scl_oe_q;
  assign scl_fall_strb = fall_q;
  assign scl_rise_strb = rise_q;
  assign mid_low_strb  = mid_low_q;
  assign mid_high_strb = mid_high_q;
  assign stretching    = stretching_q;
  assign timeout_err   = timeout_q;
  assign busy          = busy_q;

endmodule

// File: doc/scl_gen.md
Name: scl_gen

Overview:
- SCL clock generator for the APB I2C master: drives the open-drain SCL pad and produces the timing strobes for the byte/bit controller.
- Honours slave clock stretching: SCL high time is counted only after the pad is seen high.
- Works as the driver side of the SCL path, alongside the pad-side edge detector in the same master.

Parameters:
PRESCALE_WIDTH, 16, width of the half-period count and of the stretch-timeout count
SYNC_STAGES, 2, number of flops in the scl_in synchronizer (minimum 2)

Ports:
pclk  input  1  system clock
preset  input  1  asynchronous active-high reset
scl_gen_en  input  1  block enable; low forces IDLE
scl_run  input  1  level request: keep generating SCL periods while high
prescale  input  PRESCALE_WIDTH  half-period length P in pclk cycles; values below 2 are treated as 2
stretch_limit  input  PRESCALE_WIDTH  maximum WAIT_HIGH cycles; 0 disables the timeout
scl_in  input  1  raw SCL level from pad (asynchronous)
scl_oe  output  1  1 = drive SCL low, 0 = release
scl_fall_strb  output  1  one-cycle pulse on the first cycle SCL is driven low
scl_rise_strb  output  1  one-cycle pulse on the first cycle the synchronized SCL is seen high after release
mid_low_strb  output  1  one-cycle pulse in the middle of the low phase (SDA change point)
mid_high_strb  output  1  one-cycle pulse in the middle of the high phase (SDA sample point)
stretching  output  1  high while released SCL is held low externally (WAIT_HIGH)
timeout_err  output  1  one-cycle pulse when the stretch limit is exceeded
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, the FSM is in IDLE, the counters are 0, and the synchronizer flops are set to 1.
- scl_in passes through a SYNC_STAGES flop synchronizer. scl_sync is the last stage.
- States: IDLE, LOW, WAIT_HIGH, HIGH.
- Phase length: Pl = max(prescale, 2). Pl is latched on entry to LOW and held for the full period; prescale changes mid-period have no effect on that period.
- IDLE:
  - scl_oe = 0.
  - When scl_gen_en & scl_run: next cycle enter LOW with scl_oe = 1, scl_fall_strb = 1, cnt = Pl-1.
- LOW:
  - scl_oe = 1; cnt decrements every cycle.
  - mid_low_strb = 1 in the cycle cnt == Pl/2 (integer division).
  - At cnt == 0: next cycle enter WAIT_HIGH with scl_oe = 0 and stretch_cnt = 0. Exactly Pl cycles have scl_oe = 1.
- WAIT_HIGH:
  - scl_oe = 0; stretching = 1 every cycle in this state.
  - stretch_cnt increments every cycle.
  - If scl_sync == 1: next cycle enter HIGH with scl_rise_strb = 1 and cnt = Pl-1.
  - Else if stretch_limit != 0 and stretch_cnt == stretch_limit: next cycle enter IDLE with timeout_err = 1.
  - If both conditions hold in the same cycle, the rise wins and there is no error.
- HIGH:
  - scl_oe = 0; cnt decrements.
  - mid_high_strb = 1 in the cycle cnt == Pl/2.
  - At cnt == 0: if scl_run, enter LOW exactly as from IDLE (fall strobe, Pl re-latched); otherwise enter IDLE with SCL left released.
  - scl_in dropping during HIGH (another master) is ignored by this block.
- scl_run deasserted during LOW or WAIT_HIGH: the current period always completes through HIGH, then the FSM goes to IDLE.
- scl_gen_en = 0 in any state:
  - Next cycle the FSM is in IDLE with scl_oe = 0.
  - No strobes are issued during or after the abort cycle, and counters clear.
  - Takes priority over every other transition.
- Reset asserted mid-operation: immediate asynchronous return to the reset values, including scl_oe = 0.
- Strobe exclusivity: at most one of scl_fall_strb, scl_rise_strb, mid_low_strb, mid_high_strb, timeout_err is high in any cycle.
  - With Pl = 2, mid_low_strb falls on the second LOW cycle, so it never coincides with scl_fall_strb.
- Unstretched period: 2*Pl + SYNC_STAGES + 1 pclk cycles.

Test Plan:
- Reset, then prescale = 10, scl_run = 1, scl_in follows ~scl_oe with no stretch:
  - scl_oe is low for exactly 10 cycles and high for exactly 10 cycles after the rise strobe.
  - mid_low_strb fires on LOW cycle 6 and mid_high_strb on HIGH cycle 6.
  - Period = 23 cycles.
- Clock stretch: slave holds scl_in low 50 cycles after release, stretch_limit = 0 → stretching high for the whole hold; scl_rise_strb comes SYNC_STAGES+1 cycles after scl_in rises; HIGH then lasts 10 cycles.
- Timeout: scl_in stuck at 0, stretch_limit = 20 → timeout_err pulses once after 21 WAIT_HIGH cycles; FSM returns to IDLE; busy = 0; no rise strobe.
- Stop request: scl_run drops in the middle of LOW → the period completes, SCL ends released in IDLE, and exactly one scl_rise_strb follows the drop with no further fall.
- Enable abort during LOW, with prescale = 0 → scl_gen_en drop gives scl_oe = 0 on the next cycle with no strobes; on re-enable, prescale = 0 runs Pl = 2 (2-cycle low phase, mid_low_strb on the second LOW cycle).
- Asynchronous reset asserted mid-HIGH, with prescale changed mid-period → every output is 0 immediately; a prescale change from 10 to 4 during LOW takes effect only from the next fall.
